// File: rtl/prog_run_ctrl.sv
// Run controller: latches a program start PC, holds the core in load, then runs it
// until halt or watchdog expiry, counting RUN cycles and reporting completion.
module prog_run_ctrl #(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned CTR_W       = 16,
    parameter int unsigned NUM_PROGS   = 3,
    parameter int unsigned PROG_STRIDE = 256,
    parameter int unsigned TIMEOUT     = 0,
    localparam int unsigned SEL_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] ProgSel,
    input  logic             Halt,
    output logic             PcLoad,
    output logic [PC_W-1:0]  StartAddr,
    output logic             RunEn,
    output logic             Ack,
    output logic             TimedOut,
    output logic [CTR_W-1:0] CycleCt,
    output logic [SEL_W-1:0] ProgId
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             r_state, w_state_nx;
    logic               r_pcload, w_pcload_nx;
    logic               r_runen, w_runen_nx;
    logic               r_ack, w_ack_nx;
    logic               r_to, w_to_nx;
    logic [CTR_W-1:0]   r_ct, w_ct_nx, w_ct_inc;
    logic [SEL_W-1:0]   r_id, w_id_nx, w_sel;
    logic [PC_W-1:0]    r_addr, w_addr_nx;

    assign w_ct_inc = (r_ct == '1) ? r_ct : r_ct + 1'b1;
    assign w_sel    = (32'(ProgSel) < NUM_PROGS) ? ProgSel : '0;

    always_comb begin
        w_state_nx  = r_state;
        w_pcload_nx = 1'b0;
        w_runen_nx  = 1'b0;
        w_ack_nx    = r_ack;
        w_to_nx     = r_to;
        w_ct_nx     = r_ct;
        w_id_nx     = r_id;
        w_addr_nx   = r_addr;

        case (r_state)
            IDLE: if (Start) w_state_nx = LOAD;
            LOAD: if (!Start) w_state_nx = RUN;
            RUN: begin
                w_ct_nx = w_ct_inc;
                // Halt is checked first so it wins over a simultaneous watchdog expiry.
                if (Halt) begin
                    w_state_nx = DONE;
                    w_to_nx    = 1'b0;
                end else if (TIMEOUT != 0 && 32'(w_ct_inc) == TIMEOUT) begin
                    w_state_nx = DONE;
                    w_to_nx    = 1'b1;
                end
            end
            DONE: if (Start) w_state_nx = LOAD;
            default: w_state_nx = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        if (r_state == LOAD || w_state_nx == LOAD) begin
            w_id_nx   = w_sel;
            w_addr_nx = PC_W'(32'(w_sel) * PROG_STRIDE);
        end
        case (w_state_nx)
            LOAD: begin
                w_pcload_nx = 1'b1;
                w_ack_nx    = 1'b0;
                w_to_nx     = 1'b0;
                w_ct_nx     = '0;
            end
            RUN: begin
                w_runen_nx = 1'b1;
                w_ack_nx   = 1'b0;
            end
            DONE:    w_ack_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_pcload <= 1'b0;
            r_runen  <= 1'b0;
            r_ack    <= 1'b0;
            r_to     <= 1'b0;
            r_ct     <= '0;
            r_id     <= '0;
            r_addr   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_pcload <= w_pcload_nx;
            r_runen  <= w_runen_nx;
            r_ack    <= w_ack_nx;
            r_to     <= w_to_nx;
            r_ct     <= w_ct_nx;
            r_id     <= w_id_nx;
            r_addr   <= w_addr_nx;
        end
    end

    assign PcLoad    = r_pcload;
    assign StartAddr = r_addr;
    assign RunEn     = r_runen;
    assign Ack       = r_ack;
    assign TimedOut  = r_to;
    assign CycleCt   = r_ct;
    assign ProgId    = r_id;

endmodule
